// File: rtl/xsimbus_arbiter_pkg.sv
// xsimbus_arbiter_pkg: shared state encoding, defaults and width helper for the xSimBus arbiter.
package xsimbus_arbiter_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;
  localparam int ARB_TIMEOUT_DEFAULT = 16;
  function automatic int cnt_width(input int t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/xsimbus_rr_picker.sv
// xsimbus_rr_picker: combinational rotating priority encoder, scanning upward from last_id+1 with wrap.
module xsimbus_rr_picker #(
  parameter int NUM_MASTERS = 32,
  parameter int ID_W = 5
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_W-1:0]        last_id,
  output logic [ID_W-1:0]        pick_id,
  output logic                   pick_valid
);
  logic [ID_W-1:0] idx;
  // Walk from the farthest slot back to the nearest so the nearest requester wins.
  always_comb begin
    pick_id = '0;
    pick_valid = 1'b0;
    idx = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = ID_W'((int'(last_id) + i) % NUM_MASTERS);
      if (req[idx]) begin
        pick_id = idx;
        pick_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/xsimbus_arbiter.sv
// xsimbus_arbiter: round-robin bus arbiter with lock, ack/drop/timeout release and registered one-hot grant.
module xsimbus_arbiter
  import xsimbus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 32,
  parameter int ID_W = 5,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req_in,
  input  logic [NUM_MASTERS-1:0] lock_in,
  input  logic                   ack_in,
  output logic [NUM_MASTERS-1:0] grant_out,
  output logic [ID_W-1:0]        master_id_out,
  output logic                   grant_valid_out,
  output logic                   hold_flag_out,
  output logic                   timeout_out,
  output logic [ID_W-1:0]        timeout_id_out
);
  localparam int CNT_W = cnt_width(TIMEOUT);
  arb_state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0] last_id, pick_id;
  logic pick_valid, expire, done, load;

  // last_id equals the owner while busy, so one picker serves both idle and end-of-tenure arbitration.
  xsimbus_rr_picker #(.NUM_MASTERS(NUM_MASTERS), .ID_W(ID_W)) u_picker (
    .req(req_in),
    .last_id(last_id),
    .pick_id(pick_id),
    .pick_valid(pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ARB_IDLE;
    else state <= state_nx;
  end

  always_comb begin
    expire = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    done = (state == ARB_BUSY) &&
           ((ack_in && !lock_in[master_id_out]) || !req_in[master_id_out] || expire);
    load = ((state == ARB_IDLE) || done) && pick_valid;
    state_nx = load ? ARB_BUSY : (done ? ARB_IDLE : state);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_out <= '0;
      master_id_out <= '0;
      last_id <= ID_W'(NUM_MASTERS - 1);
      cnt <= '0;
      timeout_out <= 1'b0;
      timeout_id_out <= '0;
    end else begin
      timeout_out <= (state == ARB_BUSY) && expire;
      if ((state == ARB_BUSY) && expire) timeout_id_out <= master_id_out;
      if (load) begin
        grant_out <= NUM_MASTERS'(1) << pick_id;
        master_id_out <= pick_id;
        last_id <= pick_id;
        cnt <= '0;
      end else if (done) begin
        grant_out <= '0;
        cnt <= '0;
      end else if (state == ARB_BUSY) begin
        cnt <= (&cnt) ? cnt : cnt + 1'b1;
      end
    end
  end

  always_comb begin
    grant_valid_out = (state == ARB_BUSY);
    hold_flag_out = rst && |(req_in & ~grant_out);
  end
endmodule

// File: tb/tb_xsimbus_arbiter.sv
// tb_xsimbus_arbiter: directed scoreboard bench; stimulus queues expected outputs, a negedge monitor compares.
module tb_xsimbus_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] req_in, lock_in;
  logic ack_in;
  logic [31:0] grant_out;
  logic [4:0] master_id_out, timeout_id_out;
  logic grant_valid_out, hold_flag_out, timeout_out;

  typedef struct {
    logic       v;
    logic [4:0] id;
    logic       h;
    logic       to;
    logic [4:0] toid;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int stepno = 0;

  always #5 clk = ~clk;

  xsimbus_arbiter dut (
    .clk(clk),
    .rst(rst),
    .req_in(req_in),
    .lock_in(lock_in),
    .ack_in(ack_in),
    .grant_out(grant_out),
    .master_id_out(master_id_out),
    .grant_valid_out(grant_valid_out),
    .hold_flag_out(hold_flag_out),
    .timeout_out(timeout_out),
    .timeout_id_out(timeout_id_out)
  );

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  int mon_n = 0;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      mon_n++;
      chk("grant_valid", mon_n, 32'(grant_valid_out), 32'(e.v));
      chk("grant", mon_n, grant_out, e.v ? (32'd1 << e.id) : 32'd0);
      if (e.v) chk("master_id", mon_n, 32'(master_id_out), 32'(e.id));
      chk("hold_flag", mon_n, 32'(hold_flag_out), 32'(e.h));
      chk("timeout", mon_n, 32'(timeout_out), 32'(e.to));
      chk("timeout_id", mon_n, 32'(timeout_id_out), 32'(e.toid));
    end
  end

  // Apply inputs just after a negedge; the expectation is what the monitor sees one posedge later.
  task automatic step(input logic r, input logic [31:0] rq, input logic [31:0] lk, input logic a,
                      input logic ev, input logic [4:0] eid, input logic eh, input logic eto,
                      input logic [4:0] etoid);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r;
    req_in = rq;
    lock_in = lk;
    ack_in = a;
    e.v = ev;
    e.id = eid;
    e.h = eh;
    e.to = eto;
    e.toid = etoid;
    q.push_back(e);
    stepno++;
  endtask

  localparam logic [31:0] S0 = 32'h0000_0001;
  localparam logic [31:0] S29 = 32'h2000_0000;
  localparam logic [31:0] S31 = 32'h8000_0000;

  initial begin
    rst = 1'b0;
    req_in = '1;
    lock_in = '0;
    ack_in = 1'b0;
    // reset with every slot requesting
    step(0, '1, '0, 0, 0, 0, 0, 0, 0);
    step(0, '1, '0, 0, 0, 0, 0, 0, 0);
    // slot 31 alone after release
    step(1, S31, '0, 0, 1, 31, 0, 0, 0);
    // 29 and 31 alternate on unlocked acks
    step(1, S31 | S29, '0, 1, 1, 29, 1, 0, 0);
    step(1, S31 | S29, '0, 1, 1, 31, 1, 0, 0);
    step(1, S31 | S29, '0, 1, 1, 29, 1, 0, 0);
    step(1, S31 | S29, '0, 1, 1, 31, 1, 0, 0);
    // 29 granted then locked across three acks
    step(1, S31 | S29, S29, 1, 1, 29, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, S31 | S29, S29, 1, 1, 29, 1, 0, 0);
    step(1, S31 | S29, '0, 1, 1, 31, 1, 0, 0);
    // 31 drops; 29 granted, then drops with nobody else
    step(1, S29, '0, 0, 1, 29, 0, 0, 0);
    step(1, S29, '0, 0, 1, 29, 0, 0, 0);
    step(1, '0, '0, 0, 0, 0, 0, 0, 0);
    step(1, '0, '0, 0, 0, 0, 0, 0, 0);
    // slot 0 without ack: timeout at tenure cycle 16, re-granted
    step(1, S0, '0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(1, S0, '0, 0, 1, 0, 0, 0, 0);
    step(1, S0, '0, 0, 1, 0, 0, 1, 0);
    step(1, S0, '0, 0, 1, 0, 0, 0, 0);
    // reset while busy with a concurrent ack
    step(0, S0, '0, 1, 0, 0, 0, 0, 0);
    step(1, S0 | S31, '0, 0, 1, 0, 1, 0, 0);
    step(1, S0 | S31, '0, 1, 1, 31, 1, 0, 0);
    // slot 31 alone times out; timeout_id then holds 31
    for (int i = 0; i < 15; i++) step(1, S31, '0, 0, 1, 31, 0, 0, 0);
    step(1, S31, '0, 0, 1, 31, 0, 1, 31);
    step(1, '0, '0, 0, 0, 0, 0, 0, 31);
    step(1, '0, '0, 0, 0, 0, 0, 0, 31);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
